// File: rtl/stack_pkg.sv
// Shared constants and operation decode for the hardware stack.
package stack_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned SP_W   = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    OpIdle,
    OpPush,
    OpPop,
    OpSwap,
    OpBypass
  } stack_op_e;

  // Rejected pushes/pops decode to OpIdle; the error flags are derived separately.
  function automatic stack_op_e decode_op(logic push, logic pop, logic empty, logic full);
    if (push && pop) return empty ? OpBypass : OpSwap;
    if (push)        return full ? OpIdle : OpPush;
    if (pop)         return empty ? OpIdle : OpPop;
    return OpIdle;
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Control/data bundle between the decode path (master) and the stack (slave).
interface stack_unit_if #(
  parameter int unsigned DATA_W = stack_pkg::DATA_W,
  parameter int unsigned DEPTH  = stack_pkg::DEPTH
);
  localparam int unsigned SpW = $clog2(DEPTH) + 1;

  logic              Push;
  logic              Pop;
  logic              Stall;
  logic [DATA_W-1:0] PushData;
  logic              ClrErr;
  logic [DATA_W-1:0] PopData;
  logic              PopValid;
  logic [SpW-1:0]    SP;
  logic              Full;
  logic              Empty;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output Push, Pop, Stall, PushData, ClrErr,
    input  PopData, PopValid, SP, Full, Empty, Overflow, Underflow
  );

  modport slave (
    input  Push, Pop, Stall, PushData, ClrErr,
    output PopData, PopValid, SP, Full, Empty, Overflow, Underflow
  );
endinterface

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack with registered pop data, swap/bypass on simultaneous push+pop,
// and sticky overflow/underflow flags.
module stack_unit #(
  parameter int unsigned DATA_W = stack_pkg::DATA_W,
  parameter int unsigned DEPTH  = stack_pkg::DEPTH
) (
  input logic         CLK,
  input logic         RST,
  stack_unit_if.slave bus
);
  import stack_pkg::*;

  localparam int unsigned SpW   = $clog2(DEPTH) + 1;
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [SpW-1:0] SpOne  = SpW'(1);
  localparam logic [SpW-1:0] SpFull = SpW'(DEPTH);

  logic [SpW-1:0]    sp_q, sp_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              full, empty;
  stack_op_e         op;
  logic              ram_we;
  logic [AddrW-1:0]  ram_waddr;
  logic [AddrW-1:0]  top_addr;
  logic [DATA_W-1:0] top_data;

  assign full     = (sp_q == SpFull);
  assign empty    = (sp_q == '0);
  assign top_addr = AddrW'(sp_q - SpOne);
  assign op       = decode_op(bus.Push, bus.Pop, empty, full);

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (bus.PushData),
    .raddr_i (top_addr),
    .rdata_o (top_data)
  );

  always_comb begin
    sp_d        = sp_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = sp_q[AddrW-1:0];
    ovf_d       = ovf_q & ~bus.ClrErr;
    unf_d       = unf_q & ~bus.ClrErr;

    unique case (op)
      OpPush: begin
        ram_we = 1'b1;
        sp_d   = sp_q + SpOne;
      end
      OpPop: begin
        pop_data_d  = top_data;
        pop_valid_d = 1'b1;
        sp_d        = sp_q - SpOne;
      end
      OpSwap: begin
        pop_data_d  = top_data;
        pop_valid_d = 1'b1;
        ram_we      = 1'b1;
        ram_waddr   = top_addr;
      end
      OpBypass: begin
        pop_data_d  = bus.PushData;
        pop_valid_d = 1'b1;
      end
      default: ;
    endcase

    // A rejected access in the same cycle as ClrErr leaves its flag set.
    if (bus.Push && !bus.Pop && full)  ovf_d = 1'b1;
    if (bus.Pop && !bus.Push && empty) unf_d = 1'b1;

    if (bus.Stall) begin
      sp_d        = sp_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = pop_valid_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      ram_we      = 1'b0;
    end

    if (RST) ram_we = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sp_q        <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.SP        = sp_q;
  assign bus.Full      = full;
  assign bus.Empty     = empty;
  assign bus.PopData   = pop_data_q;
  assign bus.PopValid  = pop_valid_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: queue-based reference model checked every cycle,
// plus literal expectations at the points of interest.
module tb_stack_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned DP = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  stack_unit_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  stack_unit #(.DATA_W(DW), .DEPTH(DP)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: the stack is a queue, top at the back.
  logic [DW-1:0] m_stk[$];
  logic [DW-1:0] m_pd  = '0;
  logic          m_pv  = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      m_stk.delete();
      m_pd  = '0;
      m_pv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!bus.Stall) begin
      logic ovf_evt, unf_evt;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      m_pv    = 1'b0;
      if (bus.Push && bus.Pop) begin
        if (m_stk.size() == 0) m_pd = bus.PushData;
        else begin
          m_pd = m_stk[m_stk.size()-1];
          m_stk[m_stk.size()-1] = bus.PushData;
        end
        m_pv = 1'b1;
      end else if (bus.Push) begin
        if (m_stk.size() == DP) ovf_evt = 1'b1;
        else m_stk.push_back(bus.PushData);
      end else if (bus.Pop) begin
        if (m_stk.size() == 0) unf_evt = 1'b1;
        else begin
          m_pd = m_stk.pop_back();
          m_pv = 1'b1;
        end
      end
      m_ovf = ovf_evt || (m_ovf && !bus.ClrErr);
      m_unf = unf_evt || (m_unf && !bus.ClrErr);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      logic [DW+10:0] act, exp;
      int sz;
      sz  = m_stk.size();
      act = {bus.PopData, bus.PopValid, bus.SP, bus.Full, bus.Empty, bus.Overflow,
             bus.Underflow};
      exp = {m_pd, m_pv, 5'(sz), sz == DP, sz == 0, m_ovf, m_unf};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic push, input logic pop, input logic stall,
                      input logic clr, input logic [DW-1:0] d);
    @(negedge CLK);
    RST          = rst;
    bus.Push     = push;
    bus.Pop      = pop;
    bus.Stall    = stall;
    bus.ClrErr   = clr;
    bus.PushData = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_push(input logic [DW-1:0] d);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic do_pop();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    bus.Push = 1'b0; bus.Pop = 1'b0; bus.Stall = 1'b0; bus.ClrErr = 1'b0; bus.PushData = '0;
    do_reset();
    do_reset();
    chk_en = 1'b1;
    chk("rst_sp", 32'(bus.SP), 0);
    chk("rst_empty_full", {30'd0, bus.Empty, bus.Full}, 32'h2);
    chk("rst_pd_pv", {bus.PopData[30:0], bus.PopValid}, 0);

    // LIFO order
    do_push(32'h11); do_push(32'h22); do_push(32'h33);
    chk("lifo_sp3", 32'(bus.SP), 3);
    do_pop();
    chk("lifo_pop1", bus.PopData, 32'h33); chk("lifo_pv1", 32'(bus.PopValid), 1);
    chk("lifo_sp2", 32'(bus.SP), 2);
    do_pop();
    chk("lifo_pop2", bus.PopData, 32'h22); chk("lifo_sp1", 32'(bus.SP), 1);
    do_pop();
    chk("lifo_pop3", bus.PopData, 32'h11); chk("lifo_sp0", 32'(bus.SP), 0);
    chk("lifo_empty", 32'(bus.Empty), 1);
    idle();
    chk("pv_one_cycle", 32'(bus.PopValid), 0);

    // Underflow and clear
    do_reset();
    do_pop();
    chk("unf_flag", 32'(bus.Underflow), 1); chk("unf_pv", 32'(bus.PopValid), 0);
    chk("unf_sp", 32'(bus.SP), 0);          chk("unf_pd", bus.PopData, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("unf_clr", 32'(bus.Underflow), 0);

    // Fill, overflow, clear-vs-event priority, full swap
    for (int i = 0; i < 16; i++) do_push(32'h100 + 32'(i));
    chk("full_sp", 32'(bus.SP), 16); chk("full_flag", 32'(bus.Full), 1);
    do_push(32'h999);
    chk("ovf_flag", 32'(bus.Overflow), 1); chk("ovf_sp", 32'(bus.SP), 16);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h999);
    chk("ovf_beats_clr", 32'(bus.Overflow), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("ovf_clr", 32'(bus.Overflow), 0);
    do_pop();
    chk("full_pop", bus.PopData, 32'h10F); chk("full_pop_sp", 32'(bus.SP), 15);
    do_push(32'h200);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h201);
    chk("swap_full_pd", bus.PopData, 32'h200); chk("swap_full_sp", 32'(bus.SP), 16);
    do_pop();
    chk("swap_full_top", bus.PopData, 32'h201);

    // Swap and bypass
    do_reset();
    do_push(32'h55); do_push(32'hAA);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hBB);
    chk("swap_pd", bus.PopData, 32'hAA); chk("swap_sp", 32'(bus.SP), 2);
    do_pop();
    chk("swap_newtop", bus.PopData, 32'hBB);
    do_pop();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hBB);
    chk("byp_pd", bus.PopData, 32'hBB); chk("byp_sp", 32'(bus.SP), 0);
    chk("byp_pv", 32'(bus.PopValid), 1);
    chk("byp_noerr", {30'd0, bus.Overflow, bus.Underflow}, 0);

    // Stall freezes state, including a pending PopValid
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h5);
      chk("stall_sp", 32'(bus.SP), 0);
    end
    do_push(32'h5);
    chk("unstall_sp", 32'(bus.SP), 1);
    do_pop();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, '0);
    chk("stall_pv_hold", 32'(bus.PopValid), 1);
    chk("stall_pop_ignored", 32'(bus.Underflow), 0);

    // Reset overrides pop, and clears a pending PopValid
    for (int i = 0; i < 5; i++) do_push(32'h40 + 32'(i));
    chk("pre_rst_sp", 32'(bus.SP), 5);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    chk("rst_pop_sp", 32'(bus.SP), 0); chk("rst_pop_pv", 32'(bus.PopValid), 0);
    chk("rst_pop_pd", bus.PopData, 0);
    do_push(32'h77); do_pop();
    do_reset();
    chk("rst_after_pop_pv", 32'(bus.PopValid), 0);

    // Mixed traffic, checked by the model every cycle
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom);
    end

    @(negedge CLK);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of one stack word.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of stack entries (power of two, at least 2).
REQ-003 The block SHALL have one clock and one reset; reset is synchronous and active-high; port names are CLK and RST.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 Push  input  1  push request from the decode control path.
REQ-007 Pop  input  1  pop request from the decode control path.
REQ-008 Stall  input  1  pipeline stall; freezes all state.
REQ-009 PushData  input  DATA_W  word to push.
REQ-010 ClrErr  input  1  clears the sticky error flags.
REQ-011 PopData  output  DATA_W  registered popped word.
REQ-012 PopValid  output  1  PopData updated by a pop in the previous cycle.
REQ-013 SP  output  $clog2(DEPTH)+1  occupancy count / next free index.
REQ-014 Full  output  1  high when SP == DEPTH.
REQ-015 Empty  output  1  high when SP == 0.
REQ-016 Overflow  output  1  sticky: a push was rejected.
REQ-017 Underflow  output  1  sticky: a pop was rejected.

Function
REQ-018 When Stall=1, SP, the memory, PopData, PopValid and the error flags SHALL hold their values; Push, Pop and ClrErr SHALL be ignored.
REQ-019 A push only (Push=1, Pop=0, not Full) SHALL write PushData to entry SP and increment SP by one at the same edge.
REQ-020 A pop only (Pop=1, Push=0, not Empty) SHALL load entry SP-1 into PopData, decrement SP, and set PopValid at the same edge (one-cycle latency).
REQ-021 PopValid SHALL be high for exactly one cycle after each accepted pop or bypass, and low otherwise unless Stall holds it.
REQ-022 A push while Full SHALL leave SP and memory unchanged and set Overflow.
REQ-023 A pop while Empty with Push=0 SHALL leave SP and PopData unchanged, keep PopValid low, and set Underflow.
REQ-024 Push=1 and Pop=1 with Empty=0 (including Full) SHALL load the current top (entry SP-1) into PopData, write PushData to entry SP-1, keep SP unchanged, and set PopValid.
REQ-025 Push=1 and Pop=1 with Empty=1 SHALL load PushData into PopData, keep SP at 0, set PopValid, and set no error flag.
REQ-026 Full and Empty SHALL be combinational decodes of the registered SP.
REQ-027 ClrErr=1 SHALL clear Overflow and Underflow at the edge; an error event in the same cycle SHALL win, leaving its flag set.
REQ-028 SP SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-029 On RST=1 at a clock edge, SP SHALL become 0, PopData 0, and PopValid, Overflow and Underflow 0, so Empty=1 and Full=0; RST SHALL override Stall and any concurrent Push or Pop.
REQ-030 Memory contents SHALL NOT be reset, and no output SHALL depend on an unwritten entry.
REQ-031 A reset asserted between a pop edge and the following cycle SHALL clear PopValid at that reset edge.

Structure
REQ-032 Package stack_pkg SHALL hold DATA_W, DEPTH, the SP width constant, and the operation encoding (IDLE, PUSH, POP, SWAP, BYPASS) derived from {Push, Pop, Empty, Full}.
REQ-033 Storage SHALL be the sub-module stack_ram: DEPTH x DATA_W, one synchronous write port and one asynchronous read port.
REQ-034 The SP, flag and PopData logic SHALL reside in stack_unit.

Verification
REQ-035 Reset, then push 0x11, 0x22, 0x33, then pop three times -> PopData = 0x33, 0x22, 0x11 on consecutive cycles with PopValid=1; SP goes 3, 2, 1, 0; Empty=1 at the end.
REQ-036 Push 16 words 0x100..0x10F, then push 0x999 -> Full=1, SP=16, Overflow=1; a following pop returns 0x10F.
REQ-037 Pop from empty after reset -> Underflow=1, PopValid=0, SP=0, PopData=0; then ClrErr=1 -> Underflow=0.
REQ-038 With SP=2 (top 0xAA), drive Push=1, Pop=1, PushData=0xBB -> PopData=0xAA, SP=2, new top 0xBB; when empty, the same stimulus gives PopData=0xBB and SP=0.
REQ-039 Push 0x5 with Stall=1 for 3 cycles, then Stall=0 -> SP stays 0 during the stall and becomes 1 on the first unstalled edge.
REQ-040 With SP=5, assert RST together with Pop=1 -> SP=0, PopValid=0, PopData=0 after that edge.
